branch_redirect_ctrl: RTL and testbench
=======================================

BRANCH_REDIRECT_CTRL -- requirements
Module: branch_redirect_ctrl

Interface
REQ-001 The block SHALL have no parameters; all widths are fixed as listed.
REQ-002 clk  input  1  sole clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous and active-low.
REQ-004 ex_valid  input  1  the execute-stage instruction is valid.
REQ-005 ex_opcode  input  5  execute-stage opcode.
REQ-006 ex_take  input  1  execute-stage branch/jump-taken indication from the condition-code unit.
REQ-007 ex_target  input  16  execute-stage computed branch/jump target address.
REQ-008 mem_stall  input  1  memory stage stalled; pipeline frozen this cycle.
REQ-009 pc_redirect  output  1  PC mux selects pc_redirect_addr.
REQ-010 pc_redirect_addr  output  16  registered redirect target.
REQ-011 flush_ifid  output  1  convert the IF/ID register contents to a NOP.
REQ-012 flush_idex  output  1  convert the ID/EX register contents to a NOP.
REQ-013 stall_fetch  output  1  hold the PC and the IF/ID register.
REQ-014 cf_count  output  16  saturating count of accepted control-flow instructions.
REQ-015 taken_count  output  16  saturating count of accepted taken control-flow instructions.

Function
REQ-016 Control-flow (CF) opcodes SHALL be 011xx (BEQZ, BNEZ, BLTZ, BGEZ) and 001xx (J, JR, JAL, JALR); no other opcode is CF.
REQ-017 An instruction SHALL be accepted on a rising edge when state is IDLE, ex_valid=1, ex_opcode is CF and mem_stall=0.
REQ-018 The FSM SHALL have exactly three states: IDLE, REDIRECT, SETTLE.
REQ-019 IDLE -> REDIRECT SHALL occur on an accepted instruction with ex_take=1; on that same edge ex_target SHALL be captured into pc_redirect_addr.
REQ-020 An accepted instruction with ex_take=0 SHALL leave the state at IDLE (predict-not-taken), with no flush and no stall.
REQ-021 In REDIRECT the outputs SHALL be pc_redirect=1, flush_ifid=1, flush_idex=1 and stall_fetch=0.
REQ-022 REDIRECT -> SETTLE SHALL occur on the first edge with mem_stall=0; while mem_stall=1, REDIRECT and all its outputs SHALL hold unchanged.
REQ-023 In SETTLE the outputs SHALL be flush_ifid=1, pc_redirect=0, flush_idex=0 and stall_fetch=0.
REQ-024 SETTLE -> IDLE SHALL occur on the first edge with mem_stall=0; while mem_stall=1, SETTLE SHALL hold.
REQ-025 In IDLE the outputs SHALL be pc_redirect=0, flush_ifid=0 and flush_idex=0; stall_fetch SHALL equal mem_stall (combinational pass-through).
REQ-026 In REDIRECT and SETTLE, stall_fetch SHALL be 0 regardless of mem_stall.
REQ-027 CF instructions presented in EX during REDIRECT or SETTLE are wrong-path and SHALL be ignored: they cause no transition, no capture and no count.
REQ-028 pc_redirect_addr SHALL change only on capture (REQ-019) and SHALL otherwise retain its value.
REQ-029 On acceptance, cf_count SHALL increment by 1; when also taken, taken_count SHALL increment by 1 on the same edge.
REQ-030 Each counter SHALL saturate at 16'hFFFF and never wrap.
REQ-031 taken_count SHALL always be less than or equal to cf_count.
REQ-032 When ex_valid=0, the ex_opcode, ex_take and ex_target inputs SHALL be don't-care.

Reset
REQ-033 rst_n=0 SHALL immediately, without waiting for a clock edge, force state=IDLE, pc_redirect_addr=16'h0000, cf_count=0 and taken_count=0.
REQ-034 While rst_n=0, pc_redirect=0, flush_ifid=0 and flush_idex=0.
REQ-035 Reset asserted mid-REDIRECT or mid-SETTLE SHALL abort the sequence; no residual flush may appear after rst_n rises.
REQ-036 The first acceptance SHALL be possible on the first rising edge after rst_n deasserts.

Verification
REQ-037 Taken redirect: BEQZ (01100), ex_take=1, ex_target=16'h0040, mem_stall=0 -> next cycle pc_redirect=1, addr=0040, both flushes=1; following cycle flush_ifid only; then IDLE; cf_count=1, taken_count=1.
REQ-038 Not-taken branch: BNEZ (01101), ex_take=0 -> no redirect, no flush, state stays IDLE; cf_count=1, taken_count=0.
REQ-039 Stall during redirect: J (00100), target 16'h1234, mem_stall=1 for 3 cycles after acceptance -> REDIRECT outputs held 4 cycles total, then SETTLE for 1 cycle; addr stays 1234 throughout.
REQ-040 Shadow ignore: JAL taken to 16'h0100, then JR (00101) with ex_take=1, target 16'h0200 presented during REDIRECT and SETTLE -> addr stays 0100, counts stay 1/1.
REQ-041 Saturation and reset: preload 65535 accepted taken CFs, then one more -> both counts remain FFFF; rst_n pulsed low mid-REDIRECT without a clock edge -> outputs drop to 0 immediately.
REQ-042 Non-CF opcode: 11100 (SEQ), ex_valid=1, ex_take=1 -> no redirect, no count change.

Source files
------------

// File: rtl/branch_redirect_ctrl.sv
// Branch/jump redirect sequencer for the EX stage: it captures a taken target,
// drives the PC mux and pipeline flushes, and counts control-flow instructions.
//
// state    | meaning
// ---------+------------------------------------------------------------
// IDLE     | normal flow; stall_fetch follows mem_stall
// REDIRECT | PC mux selects captured target, flush IF/ID and ID/EX
// SETTLE   | flush IF/ID once more while the redirected fetch lands
module branch_redirect_ctrl (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        ex_valid,
   input  logic [4:0]  ex_opcode,
   input  logic        ex_take,
   input  logic [15:0] ex_target,
   input  logic        mem_stall,
   output logic        pc_redirect,
   output logic [15:0] pc_redirect_addr,
   output logic        flush_ifid,
   output logic        flush_idex,
   output logic        stall_fetch,
   output logic [15:0] cf_count,
   output logic [15:0] taken_count
);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] REDIRECT = 2'd1;
   localparam logic [1:0] SETTLE   = 2'd2;

   logic [1:0] state;
   logic [1:0] stateNext;
   logic       isCf;
   logic       accept;
   logic       acceptTaken;

   always_comb begin
      isCf = 1'b0;
      casez (ex_opcode)
         5'b011??: isCf = 1'b1;
         5'b001??: isCf = 1'b1;
         default:  isCf = 1'b0;
      endcase
   end

   // Wrong-path instructions in REDIRECT/SETTLE never reach acceptance.
   assign accept      = (state == IDLE) && ex_valid && isCf && !mem_stall;
   assign acceptTaken = accept && ex_take;

   always_comb begin
      stateNext = state;
      case (state)
         IDLE:     if (acceptTaken) stateNext = REDIRECT;
         REDIRECT: if (!mem_stall)  stateNext = SETTLE;
         SETTLE:   if (!mem_stall)  stateNext = IDLE;
         default:  stateNext = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= stateNext;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_redirect_addr <= 16'h0000;
      end else if (acceptTaken) begin
         pc_redirect_addr <= ex_target;
      end
   end

   // Both counters saturate independently; taken only ever steps alongside cf.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cf_count    <= 16'h0000;
         taken_count <= 16'h0000;
      end else begin
         if (accept && (cf_count != 16'hFFFF)) begin
            cf_count <= cf_count + 16'd1;
         end
         if (acceptTaken && (taken_count != 16'hFFFF)) begin
            taken_count <= taken_count + 16'd1;
         end
      end
   end

   assign pc_redirect = (state == REDIRECT);
   assign flush_idex  = (state == REDIRECT);
   assign flush_ifid  = (state == REDIRECT) || (state == SETTLE);
   assign stall_fetch = (state == IDLE) && mem_stall;

endmodule

// File: tb/tb_branch_redirect_ctrl.sv
// Self-checking bench for branch_redirect_ctrl: directed vector table, async
// reset sequences, randomized run against a behavioural model, saturation.
module tb_branch_redirect_ctrl;

   logic        clk;
   logic        rst_n;
   logic        ex_valid;
   logic [4:0]  ex_opcode;
   logic        ex_take;
   logic [15:0] ex_target;
   logic        mem_stall;
   logic        pc_redirect;
   logic [15:0] pc_redirect_addr;
   logic        flush_ifid;
   logic        flush_idex;
   logic        stall_fetch;
   logic [15:0] cf_count;
   logic [15:0] taken_count;

   int checks = 0;
   int errors = 0;

   // behavioural model: phase 0 = normal, 1 = redirect, 2 = settle
   int          mPhase;
   int          mCf;
   int          mTk;
   logic [15:0] mAddr;

   branch_redirect_ctrl dut (
      .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_opcode(ex_opcode),
      .ex_take(ex_take), .ex_target(ex_target), .mem_stall(mem_stall),
      .pc_redirect(pc_redirect), .pc_redirect_addr(pc_redirect_addr),
      .flush_ifid(flush_ifid), .flush_idex(flush_idex), .stall_fetch(stall_fetch),
      .cf_count(cf_count), .taken_count(taken_count)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        v;
      logic [4:0]  op;
      logic        tk;
      logic [15:0] tg;
      logic        st;
      logic        eR;
      logic        eFi;
      logic        eFx;
      logic        eSf;
      logic [15:0] eAddr;
      logic [15:0] eCf;
      logic [15:0] eTk;
   } vec_t;

   vec_t vecs[$];

   function automatic bit isCfOp(input logic [4:0] op);
      int n;
      n = int'(op);
      return (n >= 4 && n <= 7) || (n >= 12 && n <= 15);
   endfunction

   task automatic drive(input logic v, input logic [4:0] op, input logic tk,
                        input logic [15:0] tg, input logic st);
      ex_valid = v; ex_opcode = op; ex_take = tk; ex_target = tg; mem_stall = st;
   endtask

   task automatic mReset();
      mPhase = 0; mCf = 0; mTk = 0; mAddr = 16'h0000;
   endtask

   task automatic checkOut(input string name, input logic eR, input logic eFi,
                           input logic eFx, input logic eSf, input logic [15:0] eAddr,
                           input logic [15:0] eCf, input logic [15:0] eTk);
      logic [51:0] got, exp;
      got = {pc_redirect, flush_ifid, flush_idex, stall_fetch, pc_redirect_addr, cf_count, taken_count};
      exp = {eR, eFi, eFx, eSf, eAddr, eCf, eTk};
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got r/fi/fx/sf=%b%b%b%b addr=%h cf=%h tk=%h, expected %b%b%b%b addr=%h cf=%h tk=%h",
                  name, pc_redirect, flush_ifid, flush_idex, stall_fetch, pc_redirect_addr,
                  cf_count, taken_count, eR, eFi, eFx, eSf, eAddr, eCf, eTk);
      end
   endtask

   task automatic checkModel(input string name);
      checkOut(name, mPhase == 1, mPhase != 0, mPhase == 1,
               (mPhase == 0) ? mem_stall : 1'b0, mAddr, 16'(mCf), 16'(mTk));
   endtask

   // Called at a negedge with inputs applied: advance model and DUT one edge.
   task automatic tick();
      if (!rst_n) begin
         mReset();
      end else if (mPhase == 0) begin
         if (ex_valid && isCfOp(ex_opcode) && !mem_stall) begin
            if (mCf < 65535) mCf++;
            if (ex_take) begin
               if (mTk < 65535) mTk++;
               mAddr  = ex_target;
               mPhase = 1;
            end
         end
      end else if (!mem_stall) begin
         mPhase = (mPhase == 1) ? 2 : 0;
      end
      @(posedge clk);
      @(negedge clk);
   endtask

   task automatic addVec(input logic v, input logic [4:0] op, input logic tk,
                         input logic [15:0] tg, input logic st, input logic eR,
                         input logic eFi, input logic eFx, input logic eSf,
                         input logic [15:0] eAddr, input logic [15:0] eCf,
                         input logic [15:0] eTk);
      vec_t x;
      x.v = v; x.op = op; x.tk = tk; x.tg = tg; x.st = st; x.eR = eR; x.eFi = eFi;
      x.eFx = eFx; x.eSf = eSf; x.eAddr = eAddr; x.eCf = eCf; x.eTk = eTk;
      vecs.push_back(x);
   endtask

   initial begin
      // expected columns: outputs seen this cycle, before the edge takes the inputs
      addVec(1, 5'b01100, 1, 16'h0040, 0,  0,0,0,0, 16'h0000, 16'd0, 16'd0); // BEQZ taken
      addVec(0, 5'b00000, 0, 16'h0000, 0,  1,1,1,0, 16'h0040, 16'd1, 16'd1);
      addVec(0, 5'b00000, 0, 16'h0000, 0,  0,1,0,0, 16'h0040, 16'd1, 16'd1);
      addVec(1, 5'b01101, 0, 16'hFFFF, 0,  0,0,0,0, 16'h0040, 16'd1, 16'd1); // BNEZ not taken
      addVec(1, 5'b11100, 1, 16'h5555, 0,  0,0,0,0, 16'h0040, 16'd2, 16'd1); // SEQ ignored
      addVec(0, 5'b00000, 0, 16'h0000, 1,  0,0,0,1, 16'h0040, 16'd2, 16'd1);
      addVec(1, 5'b00100, 1, 16'h1234, 1,  0,0,0,1, 16'h0040, 16'd2, 16'd1); // J blocked by stall
      addVec(1, 5'b00100, 1, 16'h1234, 0,  0,0,0,0, 16'h0040, 16'd2, 16'd1); // J accepted
      addVec(0, 5'b00000, 0, 16'h0000, 1,  1,1,1,0, 16'h1234, 16'd3, 16'd2);
      addVec(0, 5'b00000, 0, 16'h0000, 1,  1,1,1,0, 16'h1234, 16'd3, 16'd2);
      addVec(0, 5'b00000, 0, 16'h0000, 1,  1,1,1,0, 16'h1234, 16'd3, 16'd2);
      addVec(0, 5'b00000, 0, 16'h0000, 0,  1,1,1,0, 16'h1234, 16'd3, 16'd2);
      addVec(0, 5'b00000, 0, 16'h0000, 1,  0,1,0,0, 16'h1234, 16'd3, 16'd2);
      addVec(0, 5'b00000, 0, 16'h0000, 0,  0,1,0,0, 16'h1234, 16'd3, 16'd2);
      addVec(0, 5'b00000, 0, 16'h0000, 0,  0,0,0,0, 16'h1234, 16'd3, 16'd2);
      addVec(1, 5'b00110, 1, 16'h0100, 0,  0,0,0,0, 16'h1234, 16'd3, 16'd2); // JAL taken
      addVec(1, 5'b00101, 1, 16'h0200, 0,  1,1,1,0, 16'h0100, 16'd4, 16'd3); // JR in shadow
      addVec(1, 5'b00101, 1, 16'h0200, 0,  0,1,0,0, 16'h0100, 16'd4, 16'd3);
      addVec(0, 5'b00000, 0, 16'h0000, 0,  0,0,0,0, 16'h0100, 16'd4, 16'd3);

      rst_n = 1'b0;
      drive(0, 5'd0, 0, 16'h0, 0);
      mReset();
      #1;
      checkOut("reset_state", 0, 0, 0, 0, 16'h0000, 16'd0, 16'd0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;

      foreach (vecs[i]) begin
         drive(vecs[i].v, vecs[i].op, vecs[i].tk, vecs[i].tg, vecs[i].st);
         #1;
         checkOut($sformatf("vec%0d", i), vecs[i].eR, vecs[i].eFi, vecs[i].eFx,
                  vecs[i].eSf, vecs[i].eAddr, vecs[i].eCf, vecs[i].eTk);
         #1;
         tick();
      end
      mPhase = 0; mCf = 4; mTk = 3; mAddr = 16'h0100;

      // async reset mid-REDIRECT, then acceptance on the first edge after release
      drive(1, 5'b00111, 1, 16'hBEEF, 0);
      tick();
      #1 checkModel("pre_reset_redirect");
      rst_n = 1'b0;
      #1 mReset();
      checkModel("async_reset_redirect");
      @(negedge clk);
      rst_n = 1'b1;
      drive(1, 5'b01110, 1, 16'h0ABC, 0);
      #1 checkModel("after_reset_idle");
      tick();
      #1 checkModel("first_accept_after_reset");
      drive(0, 5'd0, 0, 16'h0, 0);
      tick();
      #1 checkModel("settle_before_reset");
      rst_n = 1'b0;
      #1 mReset();
      checkModel("async_reset_settle");
      @(negedge clk);
      rst_n = 1'b1;
      for (int k = 0; k < 3; k++) begin
         #1 checkModel("no_residual_flush");
         tick();
      end

      // randomized run against the model, with occasional reset pulses
      for (int n = 0; n < 3000; n++) begin
         if ($urandom_range(0, 199) == 0) begin
            rst_n = 1'b0;
            #1 mReset();
            checkModel("rand_reset");
            @(negedge clk);
            rst_n = 1'b1;
         end
         drive(1'($urandom_range(0, 3) != 0), 5'($urandom_range(0, 31)),
               1'($urandom_range(0, 1)), 16'($urandom), 1'($urandom_range(0, 3) == 0));
         #1 checkModel("random");
         tick();
      end

      // saturation: fill cf_count with back-to-back not-taken branches
      rst_n = 1'b0;
      #1 mReset();
      @(negedge clk);
      rst_n = 1'b1;
      drive(1, 5'b01101, 0, 16'h0, 0);
      for (int n = 0; n < 65535; n++) tick();
      #1 checkOut("cf_reach_max", 0, 0, 0, 0, 16'h0000, 16'hFFFF, 16'h0000);
      tick();
      #1 checkOut("cf_saturate", 0, 0, 0, 0, 16'h0000, 16'hFFFF, 16'h0000);
      drive(1, 5'b00100, 1, 16'h7777, 0);
      #1 tick();
      #1 checkOut("taken_at_cf_max", 1, 1, 1, 0, 16'h7777, 16'hFFFF, 16'h0001);
      rst_n = 1'b0;
      #1 mReset();
      checkOut("reset_after_saturation", 0, 0, 0, 0, 16'h0000, 16'h0000, 16'h0000);
      @(negedge clk);
      rst_n = 1'b1;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
